// File: rtl/regfile_pkg.sv
// Shared register-file writeback definitions: default widths, the x0 index
// and the per-requester writeback request payload.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_REG_COUNT  = 32;
  localparam int unsigned DEF_REG_SIZE   = $clog2(DEF_REG_COUNT);

  // Architectural zero register: writes to it are accepted but dropped.
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_SIZE-1:0]   rd;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way writeback grant logic.
// Build option: WB_ARB_RR_EN adds a one-bit round-robin priority pointer;
// without it requester 0 always wins and no state exists.
// Ports:
//   clk, rstN        clock / async active-low reset (pointer build only)
//   valid0, valid1   request inputs
//   ready0, ready1   combinational one-hot-or-zero grants
module rr_arb2 (
`ifdef WB_ARB_RR_EN
  input  logic clk,
  input  logic rstN,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);

`ifdef WB_ARB_RR_EN
  logic ptr_q;
  logic ptr_d;

  // Pointer names the conflict winner; it moves to the loser after a grant.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    ptr_d  = ptr_q;
    if (valid0 && valid1) begin
      ready0 = ~ptr_q;
      ready1 = ptr_q;
    end else begin
      ready0 = valid0;
      ready1 = valid1;
    end
    if (ready0) begin
      ptr_d = 1'b1;
    end else if (ready1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: requester 0 wins every conflict.
  always_comb begin
    ready0 = valid0;
    ready1 = valid1 & ~valid0;
  end
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU (0) and LSU (1) writeback
// requests into one registered write port with one cycle of latency.
// Build option: WB_ARB_RR_EN selects round-robin conflict resolution
// (default: requester 0 has fixed priority).
// Ports:
//   clk, rstN              clock / async active-low reset
//   valid0/1, rd0/1, data0/1  writeback requests
//   ready0/1               combinational grants
//   wen, rd, data_in       registered register-file write port
//   pend_mask              registered one-hot of the staged write target
module reg_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned REG_COUNT  = DEF_REG_COUNT,
  parameter int unsigned REG_SIZE   = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  valid0,
  input  logic                  valid1,
  input  logic [REG_SIZE-1:0]   rd0,
  input  logic [REG_SIZE-1:0]   rd1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ready0,
  output logic                  ready1,
  output logic                  wen,
  output logic [REG_SIZE-1:0]   rd,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [REG_COUNT-1:0]  pend_mask
);

  logic                  wen_q, wen_d;
  logic [REG_SIZE-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [REG_COUNT-1:0]  pend_mask_q, pend_mask_d;

  rr_arb2 u_arb (
`ifdef WB_ARB_RR_EN
    .clk    (clk),
    .rstN   (rstN),
`endif
    .valid0 (valid0),
    .valid1 (valid1),
    .ready0 (ready0),
    .ready1 (ready1)
  );

  // Stage the granted request; x0 targets update rd/data but never assert wen.
  always_comb begin
    wen_d       = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    pend_mask_d = '0;
    if (valid0 && ready0) begin
      rd_d   = rd0;
      data_d = data0;
      wen_d  = (rd0 != REG_SIZE'(REG_ZERO));
    end else if (valid1 && ready1) begin
      rd_d   = rd1;
      data_d = data1;
      wen_d  = (rd1 != REG_SIZE'(REG_ZERO));
    end
    if (wen_d) begin
      pend_mask_d = REG_COUNT'(1) << rd_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wen_q       <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      pend_mask_q <= '0;
    end else begin
      wen_q       <= wen_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      pend_mask_q <= pend_mask_d;
    end
  end

  assign wen       = wen_q;
  assign rd        = rd_q;
  assign data_in   = data_q;
  assign pend_mask = pend_mask_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter (default widths). Conflict expectations
// follow the WB_ARB_RR_EN build option.
module tb_reg_wb_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        valid0, valid1;
  logic [4:0]  rd0, rd1;
  logic [31:0] data0, data1;
  logic        ready0, ready1;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic [31:0] pend_mask;

  int n_chk = 0;
  int n_err = 0;

  reg_wb_arbiter #(.DATA_WIDTH(32), .REG_COUNT(32), .REG_SIZE(5)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .valid0    (valid0),
    .valid1    (valid1),
    .rd0       (rd0),
    .rd1       (rd1),
    .data0     (data0),
    .data1     (data1),
    .ready0    (ready0),
    .ready1    (ready1),
    .wen       (wen),
    .rd        (rd),
    .data_in   (data_in),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wb_req_t mk(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_req_t q;
    q.valid = v;
    q.rd    = r;
    q.data  = d;
    return q;
  endfunction

  task automatic drive(input wb_req_t r0, input wb_req_t r1);
    valid0 = r0.valid; rd0 = r0.rd; data0 = r0.data;
    valid1 = r1.valid; rd1 = r1.rd; data1 = r1.data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic w, input logic [4:0] r,
                          input logic [31:0] d, input logic [31:0] m);
    chk({tag, ".wen"},  64'(wen),       64'(w));
    chk({tag, ".rd"},   64'(rd),        64'(r));
    chk({tag, ".data"}, 64'(data_in),   64'(d));
    chk({tag, ".pend"}, 64'(pend_mask), 64'(m));
  endtask

  wb_req_t idle;

  initial begin
    idle = mk(1'b0, 5'd0, 32'd0);
    rstN = 1'b0;
    drive(idle, idle);
    repeat (2) tick();
    chk_port("reset", 1'b0, 5'd0, 32'd0, 32'd0);

    // Release away from the clock edge.
    rstN = 1'b1;
    tick();
    chk_port("post_reset", 1'b0, 5'd0, 32'd0, 32'd0);

    // Conflict: both requesters valid every cycle.
    drive(mk(1'b1, 5'd1, 32'h1111_1111), mk(1'b1, 5'd2, 32'h2222_2222));
`ifdef WB_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready0_%0d", i), 64'(ready0), 64'((i % 2) == 0));
      chk($sformatf("rr_ready1_%0d", i), 64'(ready1), 64'((i % 2) == 1));
      tick();
      chk($sformatf("rr_wen_%0d", i), 64'(wen), 64'(1));
      chk($sformatf("rr_rd_%0d", i),  64'(rd),  64'(((i % 2) == 0) ? 1 : 2));
    end
`else
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fix_ready0_%0d", i), 64'(ready0), 64'(1));
      chk($sformatf("fix_ready1_%0d", i), 64'(ready1), 64'(0));
      tick();
      chk($sformatf("fix_wen_%0d", i),  64'(wen),     64'(1));
      chk($sformatf("fix_rd_%0d", i),   64'(rd),      64'(1));
      chk($sformatf("fix_data_%0d", i), 64'(data_in), 64'(32'h1111_1111));
    end
`endif
    drive(idle, idle);
    tick();

    // Single ALU write to r5.
    drive(mk(1'b1, 5'd5, 32'hA5A5_A5A5), idle);
    #1;
    chk("t1.ready0", 64'(ready0), 64'(1));
    chk("t1.ready1", 64'(ready1), 64'(0));
    tick();
    drive(idle, idle);
    chk_port("t1", 1'b1, 5'd5, 32'hA5A5_A5A5, 32'h0000_0020);
    #1;
    chk("idle.ready0", 64'(ready0), 64'(0));
    chk("idle.ready1", 64'(ready1), 64'(0));
    tick();
    chk_port("hold", 1'b0, 5'd5, 32'hA5A5_A5A5, 32'd0);

    // LSU write to x0: accepted, no write enable, rd/data still update.
    drive(idle, mk(1'b1, 5'd0, 32'hFFFF_FFFF));
    #1;
    chk("x0.ready1", 64'(ready1), 64'(1));
    chk("x0.ready0", 64'(ready0), 64'(0));
    tick();
    drive(idle, idle);
    chk_port("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd0);

    // LSU write to r31: top bit of pend_mask.
    drive(idle, mk(1'b1, 5'd31, 32'h1234_5678));
    #1;
    chk("r31.ready1", 64'(ready1), 64'(1));
    chk("r31.ready0", 64'(ready0), 64'(0));
    tick();
    drive(idle, idle);
    chk_port("r31", 1'b1, 5'd31, 32'h1234_5678, 32'h8000_0000);

    // Back-to-back writes to the same register keep grant order.
    drive(mk(1'b1, 5'd7, 32'h0000_0001), idle);
    tick();
    drive(idle, mk(1'b1, 5'd7, 32'h0000_0002));
    chk_port("b2b0", 1'b1, 5'd7, 32'h0000_0001, 32'h0000_0080);
    #1;
    chk("b2b.ready1", 64'(ready1), 64'(1));
    tick();
    drive(idle, idle);
    chk_port("b2b1", 1'b1, 5'd7, 32'h0000_0002, 32'h0000_0080);

    // Reset while a write is staged discards it.
    drive(mk(1'b1, 5'd3, 32'h3333_3333), idle);
    #1;
    chk("rst.ready0", 64'(ready0), 64'(1));
    tick();
    chk("rst.staged", 64'(wen), 64'(1));
    drive(idle, idle);
    rstN = 1'b0;
    #1;
    chk_port("rst_mid", 1'b0, 5'd0, 32'd0, 32'd0);
    // A request pending at reset release is arbitrated normally.
    drive(mk(1'b1, 5'd4, 32'h4444_4444), idle);
    tick();
    chk_port("rst_hold", 1'b0, 5'd0, 32'd0, 32'd0);
    rstN = 1'b1;
    #1;
    chk("rst_rise.ready0", 64'(ready0), 64'(1));
    tick();
    drive(idle, idle);
    chk_port("rst_rise", 1'b1, 5'd4, 32'h4444_4444, 32'h0000_0010);
    tick();
    chk("rst_tail.wen", 64'(wen), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the write-data width.
- REQ-002 The block SHALL have parameter REG_COUNT, default 32, the number of architectural registers.
- REQ-003 The block SHALL have parameter REG_SIZE, default $clog2(REG_COUNT), the register-index width.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
- REQ-005 The block SHALL have port rstN, input, 1 bit: the asynchronous, active-low reset.
- REQ-006 The block SHALL have ports valid0/valid1, input, 1 bit each: writeback request from requester 0 (ALU) and requester 1 (LSU).
- REQ-007 The block SHALL have ports rd0/rd1, input, REG_SIZE bits each: destination register index per requester.
- REQ-008 The block SHALL have ports data0/data1, input, DATA_WIDTH bits each: write data per requester.
- REQ-009 The block SHALL have ports ready0/ready1, output, 1 bit each: grant; a transfer occurs when valid and ready are both high in the same cycle.
- REQ-010 The block SHALL have port wen, output, 1 bit: register-file write enable.
- REQ-011 The block SHALL have port rd, output, REG_SIZE bits: register-file write index.
- REQ-012 The block SHALL have port data_in, output, DATA_WIDTH bits: register-file write data.
- REQ-013 The block SHALL have port pend_mask, output, REG_COUNT bits: one-hot mask of the register being written by the staged write; zero when no write is staged.

Function
- REQ-014 ready0/ready1 SHALL be combinational from the valid inputs and the priority state, at most one SHALL be high per cycle, and readyN SHALL never be high while validN is low.
- REQ-015 With a single valid request, that requester SHALL be granted in the same cycle.
- REQ-016 On conflict (both valid high), the requester selected by the priority policy of REQ-028 SHALL be granted and the other SHALL see ready low.
- REQ-017 A requester SHALL hold validN, rdN and dataN stable until it is granted; the block SHALL NOT check this.
- REQ-018 An accepted transfer SHALL appear on wen/rd/data_in after exactly one clock edge, giving one cycle of latency.
- REQ-019 wen/rd/data_in SHALL be registered, and wen SHALL be high for exactly one cycle per accepted non-x0 transfer.
- REQ-020 A transfer with rdN == 0 SHALL be accepted (ready high) with wen low in the following cycle.
- REQ-021 For a transfer with rdN == 0, rd and data_in SHALL still update in the following cycle.
- REQ-022 With no transfer in a cycle, wen SHALL go low at the next edge while rd and data_in hold their values.
- REQ-023 pend_mask SHALL equal (1 << rd) when wen is high and zero otherwise, and SHALL be derived from registered state only.
- REQ-024 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
- REQ-025 Two writes to the same rd in consecutive cycles SHALL appear in grant order.

Reset
- REQ-026 While rstN is low, wen, rd, data_in and pend_mask SHALL be 0, and the priority pointer SHALL be 0, so requester 0 is favoured.
- REQ-027 A reset asserted mid-operation SHALL discard any staged write, and no wen SHALL be issued for it after rstN rises; requests pending at rstN rise SHALL be arbitrated normally in the first active cycle.

Configuration
- REQ-028 With macro WB_ARB_RR_EN defined, a one-bit priority pointer SHALL select the conflict winner; after any grant, the pointer SHALL move to the non-granted requester, giving round-robin with no starvation.
- REQ-029 Without WB_ARB_RR_EN, requester 0 SHALL always win conflicts, and the priority pointer SHALL be absent, with no flop synthesised.

Structure
- REQ-030 A shared package regfile_pkg SHALL hold the DATA_WIDTH/REG_COUNT defaults, the REG_ZERO index constant, and a wb_req_t struct {valid, rd, data}.
- REQ-031 Grant logic SHALL be a sub-module rr_arb2 (2-way, pointer-based, fixed-priority under the macro-off build); the output staging and pend_mask SHALL reside in reg_wb_arbiter.

Verification
- REQ-032 The bench SHALL cover: reset release, then valid0=1, rd0=5, data0=0xA5A5A5A5 -> ready0=1 same cycle; next cycle wen=1, rd=5, data_in=0xA5A5A5A5, pend_mask=0x20.
- REQ-033 The bench SHALL cover: with WB_ARB_RR_EN, both valid for 4 cycles (rd0=1, rd1=2) -> grants 0,1,0,1; wen high 4 consecutive cycles with rd 1,2,1,2.
- REQ-034 The bench SHALL cover: without WB_ARB_RR_EN, both valid for 3 cycles -> ready0=1 every cycle, ready1=0 throughout.
- REQ-035 The bench SHALL cover: valid1=1, rd1=0, data1=0xFFFFFFFF -> ready1=1; next cycle wen=0, pend_mask=0.
- REQ-036 The bench SHALL cover: a transfer accepted, then rstN low before the next edge -> wen=0, rd=0, data_in=0; no write issued after rstN rises.
- REQ-037 The bench SHALL cover: valid0 low, valid1 high with rd1=31 -> ready1=1, ready0=0; next cycle pend_mask=0x80000000.
